// File: rtl/lcd_hd44780_responder_if.sv
// Bus between a 4-bit HD44780 host and the responder model.
// Carries the host strobe lines plus the responder's observable state.
interface lcd_hd44780_responder_if;
   logic [3:0] lcd;
   logic       enable;
   logic       register_select;
   logic       read_write;
   logic [4:0] read_addr;
   logic [7:0] read_char;
   logic [7:0] byte_data;
   logic       byte_rs;
   logic       byte_valid;
   logic [6:0] addr;
   logic       busy;
   logic       four_bit_mode;
   logic       display_on;
   logic       cursor_on;
   logic       blink_on;
   logic       increment;
   logic       protocol_error;

   modport master (
      output lcd, enable, register_select, read_write, read_addr,
      input  read_char, byte_data, byte_rs, byte_valid, addr, busy,
             four_bit_mode, display_on, cursor_on, blink_on, increment,
             protocol_error
   );

   modport slave (
      input  lcd, enable, register_select, read_write, read_addr,
      output read_char, byte_data, byte_rs, byte_valid, addr, busy,
             four_bit_mode, display_on, cursor_on, blink_on, increment,
             protocol_error
   );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-class controller model: nibble assembly on E falling edges,
// instruction subset execution and a 2x16 DDRAM with a readout port.
module lcd_hd44780_responder #(
   parameter int unsigned BUSY_LONG  = 82000,
   parameter int unsigned BUSY_SHORT = 2000
) (
   input logic                    clk,
   input logic                    rst,
   lcd_hd44780_responder_if.slave bus
);
   localparam int unsigned CW = $clog2(BUSY_LONG + 1);

   typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;

   state_t          state_q, state_d;
   logic            en_prev_q;
   logic [3:0]      hi_q, hi_d;
   logic [6:0]      ac_q, ac_d;
   logic            inc_q, inc_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic            four_q, four_d;
   logic [7:0]      byte_q, byte_d;
   logic            rs_q, rs_d, valid_q, valid_d, err_q, err_d, busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sweep_q, sweep_d;
   logic [4:0]      sweep_idx_q, sweep_idx_d;
   logic [7:0]      read_char_q;
   logic [7:0]      ddram [32];
   logic            wr_en;
   logic [4:0]      wr_idx;
   logic [7:0]      wr_data;
   logic            strobe, exec;
   logic [7:0]      exec_byte;

   // Address counter step; skips the unmapped gap between the two lines
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
      if (up) begin
         if (ac == 7'h0F)      ac_step = 7'h40;
         else if (ac == 7'h4F) ac_step = 7'h00;
         else                  ac_step = 7'(ac + 7'd1);
      end else begin
         if (ac == 7'h00)      ac_step = 7'h4F;
         else if (ac == 7'h40) ac_step = 7'h0F;
         else                  ac_step = 7'(ac - 7'd1);
      end
   endfunction

   assign strobe = en_prev_q & ~bus.enable;

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      ac_d        = ac_q;
      inc_d       = inc_q;
      disp_d      = disp_q;
      cur_d       = cur_q;
      blink_d     = blink_q;
      four_d      = four_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      cnt_d       = (cnt_q != '0) ? CW'(cnt_q - CW'(1)) : cnt_q;
      sweep_d     = sweep_q;
      sweep_idx_d = sweep_idx_q;
      wr_en       = 1'b0;
      wr_idx      = 5'd0;
      wr_data     = 8'h00;
      exec        = 1'b0;
      exec_byte   = 8'h00;

      if (sweep_q) begin
         wr_en       = 1'b1;
         wr_idx      = sweep_idx_q;
         wr_data     = 8'h20;
         sweep_idx_d = 5'(sweep_idx_q + 5'd1);
         if (sweep_idx_q == 5'd31) sweep_d = 1'b0;
      end

      // A strobe on the final busy cycle is already accepted
      if (strobe) begin
         if (bus.read_write || cnt_q > CW'(1)) begin
            err_d = 1'b1;
         end else begin
            unique case (state_q)
               INIT8: begin
                  exec      = 1'b1;
                  exec_byte = {bus.lcd, 4'h0};
                  if (bus.lcd == 4'h2) begin
                     four_d  = 1'b1;
                     state_d = NIB_HI;
                  end
               end
               NIB_HI: begin
                  hi_d    = bus.lcd;
                  state_d = NIB_LO;
               end
               NIB_LO: begin
                  exec      = 1'b1;
                  exec_byte = {hi_q, bus.lcd};
                  state_d   = NIB_HI;
               end
               default: state_d = INIT8;
            endcase
         end
      end

      if (exec) begin
         byte_d  = exec_byte;
         rs_d    = bus.register_select;
         valid_d = 1'b1;
         if (bus.register_select) begin
            wr_en   = 1'b1;
            wr_idx  = {ac_q[6], ac_q[3:0]};
            wr_data = exec_byte;
            ac_d    = ac_step(ac_q, inc_q);
            cnt_d   = CW'(BUSY_SHORT);
         end else begin
            casez (exec_byte)
               8'b1???????: begin
                  if (exec_byte[5:4] == 2'b00) begin
                     ac_d  = exec_byte[6:0];
                     cnt_d = CW'(BUSY_SHORT);
                  end else begin
                     err_d = 1'b1;
                  end
               end
               8'b001?????: cnt_d = CW'(BUSY_SHORT);
               8'b00001???: begin
                  disp_d  = exec_byte[2];
                  cur_d   = exec_byte[1];
                  blink_d = exec_byte[0];
                  cnt_d   = CW'(BUSY_SHORT);
               end
               8'b000001??: begin
                  inc_d = exec_byte[1];
                  cnt_d = CW'(BUSY_SHORT);
               end
               8'b0000001?: begin
                  ac_d  = 7'h00;
                  cnt_d = CW'(BUSY_LONG);
               end
               8'b00000001: begin
                  ac_d        = 7'h00;
                  inc_d       = 1'b1;
                  cnt_d       = CW'(BUSY_LONG);
                  sweep_d     = 1'b1;
                  sweep_idx_d = 5'd0;
               end
               default: ;
            endcase
         end
      end

      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT8;
         en_prev_q   <= 1'b0;
         hi_q        <= 4'h0;
         ac_q        <= 7'h00;
         inc_q       <= 1'b1;
         disp_q      <= 1'b0;
         cur_q       <= 1'b0;
         blink_q     <= 1'b0;
         four_q      <= 1'b0;
         byte_q      <= 8'h00;
         rs_q        <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         sweep_q     <= 1'b0;
         sweep_idx_q <= 5'd0;
         read_char_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         en_prev_q   <= bus.enable;
         hi_q        <= hi_d;
         ac_q        <= ac_d;
         inc_q       <= inc_d;
         disp_q      <= disp_d;
         cur_q       <= cur_d;
         blink_q     <= blink_d;
         four_q      <= four_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         sweep_q     <= sweep_d;
         sweep_idx_q <= sweep_idx_d;
         read_char_q <= ddram[bus.read_addr];
      end
   end

   // DDRAM contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) ddram[wr_idx] <= wr_data;
   end

   assign bus.read_char      = read_char_q;
   assign bus.byte_data      = byte_q;
   assign bus.byte_rs        = rs_q;
   assign bus.byte_valid     = valid_q;
   assign bus.addr           = ac_q;
   assign bus.busy           = busy_q;
   assign bus.four_bit_mode  = four_q;
   assign bus.display_on     = disp_q;
   assign bus.cursor_on      = cur_q;
   assign bus.blink_on       = blink_q;
   assign bus.increment      = inc_q;
   assign bus.protocol_error = err_q;
endmodule
